dm_cache_ctrl: RTL and testbench

// - Direct-mapped, write-back, write-allocate data cache. One word per line.
// - Sits between the CPU load/store port and the word-addressed main memory.
// - Acts as the initiator of the memory read_enable/write_enable/busy_wait protocol.
// - Stalls the CPU through cpu_busywait on every miss.

---
 rtl/dm_cache_ctrl_if.sv | 34 +++
 rtl/dm_cache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_if.sv
// CPU load/store port and main-memory port of dm_cache_ctrl, bundled as one interface.
// master = cache controller view, slave = CPU/memory environment view.
interface dm_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_read;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_writedata;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport master (
    input  cpu_read, cpu_write, cpu_address, cpu_writedata,
    output cpu_readdata, cpu_busywait,
    output mem_read, mem_write, mem_address, mem_writedata,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    output cpu_read, cpu_write, cpu_address, cpu_writedata,
    input  cpu_readdata, cpu_busywait,
    input  mem_read, mem_write, mem_address, mem_writedata,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate, one-word-per-line data cache controller.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned INDEX_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  dm_cache_ctrl_if.master       bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q [LINES];
  logic [DATA_W-1:0] data_d [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [TAG_W-1:0]  tag_d  [LINES];
  logic [LINES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic                  req, hit, busy;
  logic [DATA_W-1:0]     readdata;
  logic [1:0]            unused_byte_offset;

  assign idx                = bus.cpu_address[INDEX_BITS+1:2];
  assign cpu_tag            = bus.cpu_address[ADDR_W-1:INDEX_BITS+2];
  assign unused_byte_offset = bus.cpu_address[1:0];
  assign req                = bus.cpu_read | bus.cpu_write;
  assign hit                = valid_q[idx] && (tag_q[idx] == cpu_tag);

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    tag_d           = tag_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    busy            = 1'b0;
    readdata        = '0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (bus.cpu_write) begin
              data_d[idx]  = bus.cpu_writedata;
              dirty_d[idx] = 1'b1;
            end else begin
              readdata = data_q[idx];
            end
          end else begin
            busy = 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_d         = WRITEBACK;
              mem_write_d     = 1'b1;
              mem_address_d   = {tag_q[idx], idx, 2'b00};
              mem_writedata_d = data_q[idx];
            end else begin
              state_d       = ALLOCATE;
              mem_read_d    = 1'b1;
              mem_address_d = {cpu_tag, idx, 2'b00};
            end
          end
        end
      end
      WRITEBACK: begin
        busy = 1'b1;
        if (!bus.mem_busywait) begin
          state_d       = ALLOCATE;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = {cpu_tag, idx, 2'b00};
        end
      end
      ALLOCATE: begin
        busy = 1'b1;
        if (!bus.mem_busywait) begin
          state_d      = IDLE;
          mem_read_d   = 1'b0;
          data_d[idx]  = bus.mem_readdata;
          tag_d[idx]   = cpu_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Line storage needs no reset: a line is only observable once its valid bit is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  // A request held during reset would otherwise look like a miss.
  assign bus.cpu_busywait  = busy & reset;
  assign bus.cpu_readdata  = readdata;
  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic        filled_q, filled_d;

  // The retried access right after a fill hits, but belongs to the miss already counted.
  always_comb begin
    filled_d     = (state_q == ALLOCATE) && !bus.mem_busywait;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == IDLE && req) begin
      if (hit && !filled_q) hit_count_d = hit_count_q + 32'd1;
      if (!hit)             miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      filled_q     <= 1'b0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      filled_q     <= filled_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios then random accesses
// against a line-level cache model and an independent memory model.
module tb_dm_cache_ctrl;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned IB    = 3;
  localparam int unsigned LINES = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dm_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INDEX_BITS(IB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] init_word(int unsigned w);
    logic [31:0] lw;
    lw = w;
    if (w == 32'h10) return 32'hDEADBEEF;
    if (w == 32'h18) return 32'hCAFEF00D;
    return {lw[15:0] ^ 16'h5A5A, ~lw[15:0]};
  endfunction

  // Environment memory seen by the DUT
  logic [31:0] env_mem [int unsigned];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } tx_t;
  tx_t txq[$];

  int unsigned wait_cfg = 0;
  int unsigned left     = 0;
  logic [1:0]  snap_req  = 2'b00;
  logic [31:0] snap_addr = '0;
  logic [31:0] snap_data = '0;
  logic        snap_busy = 1'b0;

  // Memory responder and transaction monitor, both working at the falling edge.
  always @(negedge clk) begin
    logic [1:0]  cur;
    int unsigned wa;
    cur = {bus.mem_read, bus.mem_write};
    if (snap_req != 2'b00 && !snap_busy && reset) begin
      txq.push_back(tx_t'{wr: snap_req[0], addr: snap_addr, data: snap_data});
      if (snap_req[0]) env_mem[snap_addr >> 2] = snap_data;
    end
    if (cur != 2'b00 && reset) begin
      chk("mem_rd_wr_exclusive", {63'd0, bus.mem_read & bus.mem_write}, 64'd0);
      if (cur == snap_req && snap_busy) chk("mem_addr_stable", {32'd0, bus.mem_address}, {32'd0, snap_addr});
    end
    if (cur != snap_req) left = wait_cfg;
    if (cur != 2'b00 && left > 0) begin
      bus.mem_busywait = 1'b1;
      left--;
    end else begin
      bus.mem_busywait = 1'b0;
    end
    wa = bus.mem_address >> 2;
    bus.mem_readdata = env_mem.exists(wa) ? env_mem[wa] : init_word(wa);
    snap_req  = cur;
    snap_addr = bus.mem_address;
    snap_data = bus.mem_writedata;
    snap_busy = bus.mem_busywait;
  end

  // Reference model: cache lines plus the memory contents it expects
  logic [31:0] mdl_mem [int unsigned];
  logic [31:0] m_data  [LINES];
  int unsigned m_tag   [LINES];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  int unsigned m_hits, m_misses;

  function automatic logic [31:0] mdl_rd(int unsigned w);
    return mdl_mem.exists(w) ? mdl_mem[w] : init_word(w);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic access(bit wr, logic [31:0] addr, logic [31:0] wdata, string tag);
    int unsigned idx, tg, n, exp_n;
    tx_t         exp[$];
    idx = (addr >> 2) % LINES;
    tg  = addr >> 5;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      m_hits++;
      exp_n = 0;
    end else begin
      m_misses++;
      exp_n = 2 + wait_cfg;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp.push_back(tx_t'{wr: 1'b1, addr: (m_tag[idx] << 5) + (idx << 2), data: m_data[idx]});
        mdl_mem[(m_tag[idx] << 3) + idx] = m_data[idx];
        exp_n = exp_n + 1 + wait_cfg;
      end
      exp.push_back(tx_t'{wr: 1'b0, addr: addr & ~32'd3, data: '0});
      m_data[idx]  = mdl_rd(addr >> 2);
      m_tag[idx]   = tg;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end
    if (wr) begin
      m_data[idx]  = wdata;
      m_dirty[idx] = 1;
    end

    txq.delete();
    @(negedge clk);
    bus.cpu_write     = wr;
    bus.cpu_read      = !wr;
    bus.cpu_address   = addr;
    bus.cpu_writedata = wdata;
    #1;
    n = 0;
    while (bus.cpu_busywait && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_n));
    if (!wr) chk({tag, "_readdata"}, {32'd0, bus.cpu_readdata}, {32'd0, m_data[idx]});
    chk({tag, "_mem_tx_count"}, 64'(txq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < txq.size(); i++) begin
      chk({tag, "_tx_kind"}, {63'd0, txq[i].wr}, {63'd0, exp[i].wr});
      chk({tag, "_tx_addr"}, {32'd0, txq[i].addr}, {32'd0, exp[i].addr});
      if (exp[i].wr) chk({tag, "_tx_wdata"}, {32'd0, txq[i].data}, {32'd0, exp[i].data});
    end
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  task automatic check_stats(string tag);
`ifdef CACHE_STATS_EN
    chk({tag, "_hit_count"}, {32'd0, hit_count}, 64'(m_hits));
    chk({tag, "_miss_count"}, {32'd0, miss_count}, 64'(m_misses));
`else
    checks = checks + 0;
`endif
  endtask

  initial begin
    bus.cpu_read      = 1'b0;
    bus.cpu_write     = 1'b0;
    bus.cpu_address   = '0;
    bus.cpu_writedata = '0;
    bus.mem_busywait  = 1'b0;
    bus.mem_readdata  = '0;
    model_reset();

    // Reset with a request pending: all outputs must stay quiet
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 32'h40;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cpu_busywait", {63'd0, bus.cpu_busywait}, 64'd0);
    chk("rst_cpu_readdata", {32'd0, bus.cpu_readdata}, 64'd0);
    chk("rst_mem_read", {63'd0, bus.mem_read}, 64'd0);
    chk("rst_mem_write", {63'd0, bus.mem_write}, 64'd0);
    chk("rst_mem_address", {32'd0, bus.mem_address}, 64'd0);
    chk("rst_mem_writedata", {32'd0, bus.mem_writedata}, 64'd0);
    check_stats("rst");
    bus.cpu_read = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    access(0, 32'h40, '0, "read_miss");
    access(0, 32'h40, '0, "read_hit");
    access(1, 32'h40, 32'h12345678, "write_hit");
    access(0, 32'h40, '0, "read_after_write");
    access(0, 32'h60, '0, "dirty_evict");
    check_stats("directed");

    wait_cfg = 5;
    access(0, 32'h40, '0, "slow_alloc");
    wait_cfg = 0;

    // Abort a fill with reset, then the same address must miss again
    wait_cfg = 10;
    @(negedge clk);
    bus.cpu_read    = 1'b1;
    bus.cpu_address = 32'h60;
    @(posedge clk);
    #1;
    chk("pre_abort_mem_read", {63'd0, bus.mem_read}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_mem_read", {63'd0, bus.mem_read}, 64'd0);
    chk("abort_cpu_busywait", {63'd0, bus.cpu_busywait}, 64'd0);
    model_reset();
    bus.cpu_read = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    wait_cfg = 0;
    access(0, 32'h60, '0, "post_abort_miss");
    check_stats("post_abort");

    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 5) | ($urandom_range(0, LINES - 1) << 2) | $urandom_range(0, 3);
      wait_cfg = $urandom_range(0, 2);
      access(1'($urandom_range(0, 1)), a, $urandom, "random");
    end
    wait_cfg = 0;
    check_stats("random");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
